sram_i_rd_sched: RTL and testbench

- Controller/scheduler for one input-feature-map SRAM bank: 145-bit words, 3136 deep, registered read data one cycle after address.
- Arbitrates the single SRAM port between a feature-map loader (writes) and a conv-window read sweep.
- In RUN, generates KxK window addresses over an FM_H x FM_W map (stride 1, no padding) and streams words to the conv engine.
- Output uses a valid/ready handshake behind a small credit-controlled FIFO, so downstream backpressure never drops SRAM data.

---
 rtl/sram_i_rd_sched.sv | 205 ++++++++++++++++++++
 tb/tb_sram_i_rd_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_i_rd_sched.sv
// Single-port IFM SRAM scheduler: loader writes in IDLE, KxK window read sweep in RUN, credit-limited output FIFO.
// Optional macro SRAM_I_RD_SCHED_STALL_CNT_EN adds the stall_cnt output.
module sram_i_rd_sched #(
   parameter int WORD_AMOUNT  = 3136,
   parameter int BIT_PER_WORD = 145,
   parameter int ADDR_W       = $clog2(WORD_AMOUNT),
   parameter int FM_H         = 56,
   parameter int FM_W         = 56,
   parameter int K            = 3,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [BIT_PER_WORD-1:0] wr_data,
   output logic                    sram_we,
   output logic [ADDR_W-1:0]       sram_addr,
   output logic [BIT_PER_WORD-1:0] sram_din,
   input  logic [BIT_PER_WORD-1:0] sram_dout,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [BIT_PER_WORD-1:0] rd_data,
   output logic                    rd_last,
   output logic                    rd_end,
   output logic                    busy,
   output logic                    done
`ifdef SRAM_I_RD_SCHED_STALL_CNT_EN
   ,
   output logic [31:0]             stall_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(K - 1);
   localparam logic [ADDR_W-1:0] OX_LAST  = ADDR_W'(FM_W - K);
   localparam logic [ADDR_W-1:0] OY_LAST  = ADDR_W'(FM_H - K);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FM_W);
   localparam logic [ADDR_W-1:0] WIN_WRAP = ADDR_W'(K);
   localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
   logic [ADDR_W-1:0] winBase_q, winBase_d, rowBase_q, rowBase_d, addr_q, addr_d;
   logic              infl_q, inflLast_q, inflEnd_q;
   logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]  count_q;
   logic              done_q;
   logic [BIT_PER_WORD+1:0] fifoMem [FIFO_DEPTH];

   logic              issue, issueLast, issueEnd, push, pop, headLast, headEnd, doneSet;
   logic [CNT_W:0]    credit;

   assign push      = infl_q;
   assign rd_valid  = (count_q != '0);
   assign pop       = rd_valid && rd_ready;
   assign {headEnd, headLast, rd_data} = fifoMem[rdPtr_q];
   assign rd_last   = rd_valid && headLast;
   assign rd_end    = rd_valid && headEnd;
   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = done_q;
   // A read in flight already owns a FIFO slot, so it counts against the credit.
   assign credit    = (CNT_W+1)'(count_q) + (CNT_W+1)'(infl_q);
   assign issueLast = (kx_q == K_LAST) && (ky_q == K_LAST);
   assign issueEnd  = issueLast && (ox_q == OX_LAST) && (oy_q == OY_LAST);

   always_comb begin
      state_d   = state_q;
      kx_d      = kx_q;
      ky_d      = ky_q;
      ox_d      = ox_q;
      oy_d      = oy_q;
      winBase_d = winBase_q;
      rowBase_d = rowBase_q;
      addr_d    = addr_q;
      issue     = 1'b0;
      doneSet   = 1'b0;
      wr_ready  = 1'b0;
      sram_we   = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      case (state_q)
         IDLE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               sram_we   = 1'b1;
               sram_addr = wr_addr;
               sram_din  = wr_data;
            end
            if (start) begin
               state_d   = RUN;
               kx_d      = '0;
               ky_d      = '0;
               ox_d      = '0;
               oy_d      = '0;
               winBase_d = '0;
               rowBase_d = '0;
               addr_d    = '0;
            end
         end
         RUN: begin
            sram_addr = addr_q;
            if (credit < CREDIT_MAX) begin
               issue = 1'b1;
               // winBase tracks the window origin, rowBase the current window row; only adds are needed.
               if (kx_q != K_LAST) begin
                  kx_d   = kx_q + 1'b1;
                  addr_d = addr_q + 1'b1;
               end else if (ky_q != K_LAST) begin
                  kx_d      = '0;
                  ky_d      = ky_q + 1'b1;
                  rowBase_d = rowBase_q + ROW_STEP;
                  addr_d    = rowBase_q + ROW_STEP;
               end else if (ox_q != OX_LAST) begin
                  kx_d      = '0;
                  ky_d      = '0;
                  ox_d      = ox_q + 1'b1;
                  winBase_d = winBase_q + 1'b1;
                  rowBase_d = winBase_q + 1'b1;
                  addr_d    = winBase_q + 1'b1;
               end else if (oy_q != OY_LAST) begin
                  kx_d      = '0;
                  ky_d      = '0;
                  ox_d      = '0;
                  oy_d      = oy_q + 1'b1;
                  winBase_d = winBase_q + WIN_WRAP;
                  rowBase_d = winBase_q + WIN_WRAP;
                  addr_d    = winBase_q + WIN_WRAP;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && headEnd) begin
               state_d = IDLE;
               doneSet = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         kx_q       <= '0;
         ky_q       <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         winBase_q  <= '0;
         rowBase_q  <= '0;
         addr_q     <= '0;
         infl_q     <= 1'b0;
         inflLast_q <= 1'b0;
         inflEnd_q  <= 1'b0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         kx_q       <= kx_d;
         ky_q       <= ky_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         winBase_q  <= winBase_d;
         rowBase_q  <= rowBase_d;
         addr_q     <= addr_d;
         infl_q     <= issue;
         inflLast_q <= issue && issueLast;
         inflEnd_q  <= issue && issueEnd;
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop) rdPtr_q <= rdPtr_q + 1'b1;
         count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
         done_q     <= doneSet;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifoMem[wrPtr_q] <= {inflEnd_q, inflLast_q, sram_dout};
   end

`ifdef SRAM_I_RD_SCHED_STALL_CNT_EN
   logic [31:0] stallCnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         stallCnt_q <= '0;
      end else if (busy && rd_valid && !rd_ready && (stallCnt_q != '1)) begin
         stallCnt_q <= stallCnt_q + 1'b1;
      end
   end

   assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_sram_i_rd_sched.sv
// Directed bench for sram_i_rd_sched: 4x4 map / K=3 sweeps with a behavioural SRAM, plus a 3x3 single-window instance.
module tb_sram_i_rd_sched;

   localparam int BPW = 145;
   localparam int AW  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           start, wr_valid, wr_ready, sram_we;
   logic [AW-1:0]  wr_addr, sram_addr;
   logic [BPW-1:0] wr_data, sram_din, sram_dout, rd_data;
   logic           rd_valid, rd_ready, rd_last, rd_end, busy, done;
`ifdef SRAM_I_RD_SCHED_STALL_CNT_EN
   logic [31:0]    stall_cnt, stall_cnt2;
`endif

   logic           start2, wrValid2, wrReady2, sramWe2;
   logic [AW-1:0]  wrAddr2, sramAddr2;
   logic [BPW-1:0] wrData2, sramDin2, sramDout2, rdData2;
   logic           rdValid2, rdReady2, rdLast2, rdEnd2, busy2, done2;

   sram_i_rd_sched #(.WORD_AMOUNT(16), .BIT_PER_WORD(BPW), .FM_H(4), .FM_W(4), .K(3), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_end(rd_end), .busy(busy), .done(done)
`ifdef SRAM_I_RD_SCHED_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   sram_i_rd_sched #(.WORD_AMOUNT(9), .BIT_PER_WORD(BPW), .FM_H(3), .FM_W(3), .K(3), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .wr_valid(wrValid2), .wr_ready(wrReady2),
      .wr_addr(wrAddr2), .wr_data(wrData2), .sram_we(sramWe2), .sram_addr(sramAddr2),
      .sram_din(sramDin2), .sram_dout(sramDout2), .rd_valid(rdValid2), .rd_ready(rdReady2),
      .rd_data(rdData2), .rd_last(rdLast2), .rd_end(rdEnd2), .busy(busy2), .done(done2)
`ifdef SRAM_I_RD_SCHED_STALL_CNT_EN
      , .stall_cnt(stall_cnt2)
`endif
   );

   // Behavioural single-port SRAMs with registered read data.
   logic [BPW-1:0] mem [16];
   logic [BPW-1:0] mem2 [9];

   always @(posedge clk) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      sram_dout <= mem[sram_addr];
   end

   always @(posedge clk) begin
      if (sramWe2 && (sramAddr2 < 4'd9)) mem2[sramAddr2] <= sramDin2;
      sramDout2 <= (sramAddr2 < 4'd9) ? mem2[sramAddr2] : '0;
   end

   typedef struct {
      int addr;
      bit last;
      bit endw;
   } vec_t;

   int nCompared = 0;
   int nMismatched = 0;
   vec_t vecs [36];
   int addrList [36] = '{0, 1, 2, 4, 5, 6, 8, 9, 10,
                         1, 2, 3, 5, 6, 7, 9, 10, 11,
                         4, 5, 6, 8, 9, 10, 12, 13, 14,
                         5, 6, 7, 9, 10, 11, 13, 14, 15};
   logic [BPW-1:0] expMem [16];

   task automatic checkOutput(input string name, input logic [BPW-1:0] act, input logic [BPW-1:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " rd_valid"}, rd_valid, 0);
      checkOutput({tag, " rd_last"}, rd_last, 0);
      checkOutput({tag, " rd_end"}, rd_end, 0);
      checkOutput({tag, " busy"}, busy, 0);
      checkOutput({tag, " done"}, done, 0);
      checkOutput({tag, " sram_we"}, sram_we, 0);
      checkOutput({tag, " sram_addr"}, sram_addr, 0);
      checkOutput({tag, " sram_din"}, sram_din, 0);
      checkOutput({tag, " wr_ready"}, wr_ready, 1);
`ifdef SRAM_I_RD_SCHED_STALL_CNT_EN
      checkOutput({tag, " stall_cnt"}, stall_cnt, 0);
`endif
   endtask

   task automatic applyStimulus(input int a, input logic [BPW-1:0] d);
      @(posedge clk);
      #1 wr_valid = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      expMem[a] = d;
      @(negedge clk);
      if (a == 5) begin
         checkOutput("load wr_ready", wr_ready, 1);
         checkOutput("load sram_we", sram_we, 1);
         checkOutput("load sram_addr", sram_addr, 5);
         checkOutput("load sram_din", sram_din, d);
      end
   endtask

   // mode 0: ready high, 1: backpressure, 2: write/start lockout, 3: reset after word 10, 4: start with write.
   task automatic runSweep(input int mode);
      int n, cyc, firstValid, endCyc, doneCnt, maxOut, stalls, outs;
      n = 0; cyc = 0; firstValid = -1; endCyc = -1; doneCnt = 0; maxOut = 0; stalls = 0;
      @(posedge clk);
      #1 start = 1'b1;
      rd_ready = 1'b1;
      if (mode == 4) begin
         wr_valid = 1'b1;
         wr_addr = '0;
         wr_data = 'h55;
         expMem[0] = 'h55;
      end
      while (cyc < 400) begin
         @(negedge clk);
         outs = int'(dut.count_q) + int'(dut.infl_q);
         if (outs > maxOut) maxOut = outs;
         if (rd_valid && firstValid < 0) firstValid = cyc;
         if (busy && rd_valid && !rd_ready) stalls++;
         if (mode == 2 && wr_valid) begin
            checkOutput("lockout wr_ready", wr_ready, 0);
            checkOutput("lockout sram_we", sram_we, 0);
         end
         if (done) begin
            doneCnt++;
            checkOutput("busy with done", busy, 0);
            checkOutput("done cycle", cyc, endCyc + 1);
         end
         if (rd_valid && rd_ready) begin
            if (n < 36) begin
               checkOutput("rd_data", rd_data, expMem[vecs[n].addr]);
               checkOutput("rd_last", rd_last, vecs[n].last);
               checkOutput("rd_end", rd_end, vecs[n].endw);
            end else begin
               checkOutput("extra word", n, 35);
            end
            if (rd_end) endCyc = cyc;
            n++;
         end
         if (mode == 3 && n == 10) begin
            #1 rst_n = 1'b0;
            #1 checkResetOutputs("midreset");
            @(posedge clk);
            #2 rst_n = 1'b1;
            start = 1'b0;
            rd_ready = 1'b1;
            return;
         end
         if (endCyc >= 0 && cyc >= endCyc + 3) break;
         @(posedge clk);
         #1 cyc++;
         start = 1'b0;
         wr_valid = 1'b0;
         if (mode == 1) rd_ready = (cyc >= 12 && cyc < 32) ? 1'b0 : ($urandom_range(0, 2) != 0);
         if (mode == 2) begin
            wr_valid = (cyc >= 5 && cyc <= 8);
            wr_addr = 4'd3;
            wr_data = 'h1FF;
            start = (cyc == 10);
         end
      end
      rd_ready = 1'b1;
      checkOutput("word count", n, 36);
      checkOutput("done count", doneCnt, 1);
      checkOutput("outstanding within 4", maxOut <= 4, 1);
      if (mode == 0) begin
         checkOutput("first valid latency", firstValid, 3);
         checkOutput("last word cycle", endCyc, 38);
      end
`ifdef SRAM_I_RD_SCHED_STALL_CNT_EN
      if (mode == 1) checkOutput("stall_cnt", stall_cnt, stalls);
`endif
   endtask

   initial begin
      int n2, done2Cnt;
      start = 0; wr_valid = 0; wr_addr = '0; wr_data = '0; rd_ready = 1'b1;
      start2 = 0; wrValid2 = 0; wrAddr2 = '0; wrData2 = '0; rdReady2 = 1'b1;
      for (int i = 0; i < 36; i++) begin
         vecs[i].addr = addrList[i];
         vecs[i].last = (i % 9 == 8);
         vecs[i].endw = (i == 35);
      end
      #12 checkResetOutputs("por");
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int a = 0; a < 16; a++) applyStimulus(a, BPW'(a));
      @(posedge clk);
      #1 wr_valid = 1'b0;

      runSweep(0);
      runSweep(1);
      runSweep(2);
      runSweep(0);
      runSweep(3);
      runSweep(0);
      runSweep(4);

      // Single-window map: rd_last and rd_end must land on the same, ninth word.
      for (int a = 0; a < 9; a++) begin
         @(posedge clk);
         #1 wrValid2 = 1'b1;
         wrAddr2 = AW'(a);
         wrData2 = BPW'(a + 100);
      end
      @(posedge clk);
      #1 wrValid2 = 1'b0;
      start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      n2 = 0;
      done2Cnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (rdValid2 && rdReady2) begin
            checkOutput("single data", rdData2, BPW'(n2 + 100));
            checkOutput("single rd_last", rdLast2, (n2 == 8));
            checkOutput("single rd_end", rdEnd2, (n2 == 8));
            n2++;
         end
         if (done2) done2Cnt++;
         @(posedge clk);
         #1;
      end
      checkOutput("single word count", n2, 9);
      checkOutput("single done count", done2Cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
